csa_accum_seq: RTL

CSA_ACCUM_SEQ -- requirements
Module: csa_accum_seq

---
 rtl/csa_accum_seq.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/csa_accum_seq.sv
`default_nettype none
// ============================================================================
//  Module   : csa_accum_seq
//  Purpose  : Group accumulator. Operands are folded into a carry-save pair
//             (S, C) by a row of 3:2 counters, one operand per cycle. After
//             the operand flagged in_last, one RESOLVE cycle adds S+C. The
//             result is then held until the consumer takes it.
//  Revision : 1.0  initial release
//
//  Parameters
//    WIDTH      operand width (unsigned)
//    ACC_WIDTH  accumulator/result width, >= WIDTH and >= 2
//
//  Ports
//    clk        rising-edge clock
//    rst        synchronous active-high reset
//    in_valid   operand offered          in_ready  operand accepted this cycle
//    in_data    operand (zero-extended)  in_last   final operand of the group
//    out_valid  result available         out_ready consumer takes the result
//    out_sum    group sum mod 2^ACC_WIDTH
//    out_cnt    operand count, saturating at 255
//    out_ovf    sticky per-group overflow (only with CSA_ACCUM_OVF_EN)
//
//  Build option
//    CSA_ACCUM_OVF_EN  when defined, adds out_ovf and its tracking logic
// ============================================================================
module csa_accum_seq #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic [7:0]           out_cnt
`ifdef CSA_ACCUM_OVF_EN
  ,
  output logic                 out_ovf
`endif
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACCUM   = 2'd1;
  localparam logic [1:0] S_RESOLVE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]           r_state;
  logic [ACC_WIDTH-1:0] r_s;
  logic [ACC_WIDTH-1:0] r_c;
  logic [ACC_WIDTH-1:0] r_sum;
  logic [7:0]           r_cnt;

  logic                 w_accept;
  logic [ACC_WIDTH-1:0] w_x;
  logic [ACC_WIDTH-1:0] w_s_nxt;
  logic [ACC_WIDTH-2:0] w_maj_lo;
  logic [ACC_WIDTH-1:0] w_c_nxt;
  logic [ACC_WIDTH-1:0] w_sum;

  assign in_ready  = (r_state == S_IDLE) || (r_state == S_ACCUM);
  assign out_valid = (r_state == S_DONE);
  assign out_sum   = r_sum;
  assign out_cnt   = r_cnt;
  assign w_accept  = in_valid && in_ready;

  assign w_x     = ACC_WIDTH'(in_data);
  assign w_s_nxt = r_s ^ r_c ^ w_x;
  // Majority of the low bits only; each shifts up one place into C.
  // The MSB majority is the discarded carry and is only needed for out_ovf.
  assign w_maj_lo = (r_s[ACC_WIDTH-2:0] & r_c[ACC_WIDTH-2:0])
                  | (r_s[ACC_WIDTH-2:0] & w_x[ACC_WIDTH-2:0])
                  | (r_c[ACC_WIDTH-2:0] & w_x[ACC_WIDTH-2:0]);
  assign w_c_nxt  = {w_maj_lo, 1'b0};

`ifdef CSA_ACCUM_OVF_EN
  logic                 r_ovf;
  logic                 w_drop;
  logic [ACC_WIDTH:0]   w_full;

  assign w_drop  = (r_s[ACC_WIDTH-1] & r_c[ACC_WIDTH-1])
                 | (r_s[ACC_WIDTH-1] & w_x[ACC_WIDTH-1])
                 | (r_c[ACC_WIDTH-1] & w_x[ACC_WIDTH-1]);
  assign w_full  = {1'b0, r_s} + {1'b0, r_c};
  assign w_sum   = w_full[ACC_WIDTH-1:0];
  assign out_ovf = r_ovf;

  // Sticky for the whole group. It always returns to 0 on the way into IDLE,
  // so no separate clear is needed at the start of a group.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_ACCUM: if (w_accept && w_drop)   r_ovf <= 1'b1;
        S_RESOLVE:       if (w_full[ACC_WIDTH])    r_ovf <= 1'b1;
        S_DONE:          if (out_ready)            r_ovf <= 1'b0;
        default:                                   r_ovf <= 1'b0;
      endcase
    end
  end
`else
  assign w_sum = r_s + r_c;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_s     <= '0;
      r_c     <= '0;
      r_sum   <= '0;
      r_cnt   <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE, S_ACCUM: begin
          if (w_accept) begin
            r_s     <= w_s_nxt;
            r_c     <= w_c_nxt;
            if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
            r_state <= in_last ? S_RESOLVE : S_ACCUM;
          end
        end
        S_RESOLVE: begin
          r_sum   <= w_sum;
          r_state <= S_DONE;
        end
        S_DONE: begin
          // r_sum/r_cnt are left untouched here so the result is stable
          // for as long as the consumer stalls.
          if (out_ready) begin
            r_s     <= '0;
            r_c     <= '0;
            r_cnt   <= 8'd0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
